pixel_row_readout: RTL and testbench
====================================

// Module: pixel_row_readout
// PURPOSE
//  Downstream consumer of the pixel array's tri-state data bus. It samples one
//  row of pixel codes while that row's read line is high, and commits the row
//  to a 2-entry row FIFO when read drops. It then serialises the stored rows
//  as a pixel stream with valid/ready handshake and row/col/frame markers.
//  Sits between the pixel array / readout FSM and downstream image processing.
// PARAMETERS
//  H_PIXELS    2   pixels per row (bus lanes)
//  V_PIXELS    2   rows; width of read vector
//  DW          8   bits per pixel code
//  ROW_FIFO    2   row-buffer depth in rows (power of two, >=2)
// PORTS
//  clk         in   1           clock; all logic on rising edge
//  reset       in   1           asynchronous, active-high
//  read        in   V_PIXELS    one-hot row-read strobes from readout FSM
//  pix_data    in   H_PIXELS*DW pixel bus; lane j = bits [j*DW +: DW]
//  out_valid   out  1           stream word valid
//  out_ready   in   1           downstream accepts word
//  out_data    out  DW          pixel code
//  out_col     out  clog2(H)    column of out_data (min width 1)
//  out_row     out  clog2(V)    row of out_data (min width 1)
//  out_sof     out  1           first pixel of frame (row 0, col 0)
//  out_eol     out  1           last column of a row
//  out_eof     out  1           last column of row V_PIXELS-1
//  overflow    out  1           sticky: row dropped, FIFO full at commit
//  proto_err   out  1           sticky: >1 read bit high in one cycle
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, capture FSM in IDLE, column counter 0.
//   Reset mid-row discards the partial row and all buffered rows.
//  Capture FSM:
//   - IDLE: on a cycle with exactly one read[i] high, latch pix_data into the
//     shadow register, record i, and go to CAPTURE.
//   - CAPTURE: on each cycle read[i] stays high, re-latch pix_data, so the last
//     sample before release wins. On the first cycle read[i] is low, go to
//     COMMIT; this sample is not taken.
//   - COMMIT (1 cycle): if the FIFO is not full, push {row i, shadow}.
//     Otherwise set overflow and drop the row. Then go to IDLE.
//     A new read in the COMMIT cycle is ignored; the FSM re-arms from IDLE.
//  Multi-hot read in any state:
//   - set proto_err;
//   - capture nothing that cycle;
//   - in CAPTURE, abort to IDLE without committing.
//  A read bit other than i rising while in CAPTURE counts as multi-hot if i is
//   still high. If i has dropped, COMMIT takes priority and the new read is
//   ignored.
//  Output side:
//   - out_valid = FIFO not empty.
//   - out_data = lane col_cnt of the head row; out_row = head row index.
//   - out_col = col_cnt.
//   - A transfer occurs on out_valid & out_ready and increments col_cnt.
//   - At col_cnt == H_PIXELS-1, a transfer pops the row and wraps col_cnt to 0.
//  Markers:
//   - out_sof = valid & row==0 & col==0.
//   - out_eol = valid & col==H_PIXELS-1.
//   - out_eof = out_eol & row==V_PIXELS-1.
//  Markers are combinational from registered state. out_data and markers are
//   stable while valid & !ready.
//  Simultaneous push (COMMIT) and pop in one cycle: both occur. When the FIFO
//   is full, a pop that same cycle does not free the slot, so overflow is set.
//  Latency: row at COMMIT edge -> out_valid next cycle when the FIFO was empty.
//   Best case throughput is 1 pixel/clk.
//  overflow and proto_err clear only on reset.
// TESTING
//  1. Reset, read=2'b01 for 3 clks, bus lanes {8'h11,8'h22} then {8'h33,8'h44}
//     in the last cycle, ready=1 -> stream 8'h33(c0,r0,sof), 8'h44(c1,eol).
//  2. Full frame: row0 {0A,0B} then row1 {0C,0D}, ready=1
//     -> 0A sof, 0B eol, 0C, 0D eol+eof; FIFO empty after.
//  3. ready=0, three rows committed -> first two kept, third dropped,
//     overflow=1. Then ready=1 -> only rows 0,1 emitted.
//  4. read=2'b11 mid-CAPTURE -> proto_err=1, no row pushed, out_valid stays 0.
//  5. ready toggling 1-0-1 every clk -> out_data/markers hold while stalled,
//     no pixel lost or duplicated.
//  6. Assert reset during CAPTURE with one row buffered -> out_valid=0 next
//     cycle, flags 0, next clean row streams normally.

Source files
------------

// File: rtl/pixel_row_readout.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_row_readout
//  Description : Captures one row of pixel codes from the pixel-array bus while
//                that row's read strobe is high, commits it to a small row FIFO
//                on strobe release, and serialises buffered rows as a pixel
//                stream with valid/ready handshake and sof/eol/eof markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_row_readout #(
    parameter int H_PIXELS = 2,
    parameter int V_PIXELS = 2,
    parameter int DW       = 8,
    parameter int ROW_FIFO = 2
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [V_PIXELS-1:0]                                read,
    input  logic [H_PIXELS*DW-1:0]                             pix_data,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [DW-1:0]                                      out_data,
    output logic [((H_PIXELS > 1) ? $clog2(H_PIXELS) : 1)-1:0] out_col,
    output logic [((V_PIXELS > 1) ? $clog2(V_PIXELS) : 1)-1:0] out_row,
    output logic                                               out_sof,
    output logic                                               out_eol,
    output logic                                               out_eof,
    output logic                                               overflow,
    output logic                                               proto_err
);

    localparam int c_CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int c_RW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int c_AW = $clog2(ROW_FIFO);
    localparam int c_BW = H_PIXELS * DW;

    localparam logic [c_AW:0]   c_PTR_ONE = (c_AW + 1)'(1);
    localparam logic [c_CW-1:0] c_COL_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_COL_MAX = c_CW'(H_PIXELS - 1);
    localparam logic [c_RW-1:0] c_ROW_MAX = c_RW'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_BW-1:0]   r_shadow;
    logic [c_RW-1:0]   r_row_idx;

    logic [c_BW-1:0]   r_mem_data [ROW_FIFO];
    logic [c_RW-1:0]   r_mem_row  [ROW_FIFO];
    logic [c_AW:0]     r_wptr;
    logic [c_AW:0]     r_rptr;

    logic [c_CW-1:0]   r_col;
    logic              r_overflow;
    logic              r_proto_err;

    logic              w_multi;
    logic              w_one;
    logic [c_RW-1:0]   w_read_idx;
    logic              w_hold;
    logic              w_latch;
    logic              w_commit;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_xfer;
    logic              w_last;
    logic              w_pop;
    logic [c_BW-1:0]   w_head_data;
    logic [c_RW-1:0]   w_head_row;

    // Classify the read strobes: more than one bit set is a protocol error.
    always_comb begin
        w_multi    = |(read & (read - V_PIXELS'(1)));
        w_one      = (|read) & ~w_multi;
        w_read_idx = '0;
        for (int k = 0; k < V_PIXELS; k++) begin
            if (read[k]) begin
                w_read_idx = c_RW'(k);
            end
        end
        w_hold = read[r_row_idx];
    end

    // Capture FSM next state; multi-hot suppresses sampling and aborts a capture.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_one) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_multi) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hold) begin
                    w_latch = 1'b1;
                end else begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO status and stream handshake. Fullness is judged before any pop in
    // the same cycle, so a commit into a full FIFO always drops the row.
    always_comb begin
        w_empty     = (r_wptr == r_rptr);
        w_full      = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                      (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
        w_push      = w_commit & ~w_full;
        w_head_data = r_mem_data[r_rptr[c_AW-1:0]];
        w_head_row  = r_mem_row[r_rptr[c_AW-1:0]];
        w_last      = (r_col == c_COL_MAX);
        w_xfer      = ~w_empty & out_ready;
        w_pop       = w_xfer & w_last;
    end

    // Capture FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow row register: last in-row sample wins; row index recorded on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow  <= '0;
            r_row_idx <= '0;
        end else if (w_latch) begin
            r_shadow <= pix_data;
            if (r_state == S_IDLE) begin
                r_row_idx <= w_read_idx;
            end
        end
    end

    // Row FIFO storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ROW_FIFO; k++) begin
                r_mem_data[k] <= '0;
                r_mem_row[k]  <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr[c_AW-1:0]] <= r_shadow;
                r_mem_row[r_wptr[c_AW-1:0]]  <= r_row_idx;
                r_wptr                       <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    // Column counter walks the head row and wraps when the row is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
        end else if (w_xfer) begin
            r_col <= w_last ? '0 : r_col + c_COL_ONE;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_overflow  <= r_overflow | (w_commit & w_full);
            r_proto_err <= r_proto_err | w_multi;
        end
    end

    // Stream outputs and markers, all decoded from registered state only.
    always_comb begin
        out_valid = ~w_empty;
        out_data  = w_head_data[32'(r_col) * DW +: DW];
        out_col   = r_col;
        out_row   = w_head_row;
        out_sof   = out_valid & (w_head_row == '0) & (r_col == '0);
        out_eol   = out_valid & w_last;
        out_eof   = out_eol & (w_head_row == c_ROW_MAX);
        overflow  = r_overflow;
        proto_err = r_proto_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_row_readout
//  Description : Self-checking bench for pixel_row_readout: directed table,
//                hand-written corner sequences and random traffic compared
//                against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_row_readout;

    localparam int H  = 2;
    localparam int V  = 2;
    localparam int DW = 8;
    localparam int RF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  read = '0;
    logic [15:0] pix_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [0:0]  out_col;
    logic [0:0]  out_row;
    logic        out_sof, out_eol, out_eof, overflow, proto_err;

    pixel_row_readout #(.H_PIXELS(H), .V_PIXELS(V), .DW(DW), .ROW_FIFO(RF)) dut (
        .clk(clk), .reset(reset), .read(read), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_row(out_row), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .overflow(overflow),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int         row;
        logic [7:0] px [H];
    } row_t;

    row_t       m_q [$];
    int         m_col;
    bit         m_cap, m_commit;
    int         m_idx;
    logic [7:0] m_sh [H];
    bit         m_ovf, m_perr;

    function automatic void m_reset();
        m_q.delete();
        m_col = 0; m_cap = 0; m_commit = 0; m_idx = 0;
        m_ovf = 0; m_perr = 0;
        for (int j = 0; j < H; j++) m_sh[j] = '0;
    endfunction

    function automatic void m_step(input logic [1:0] rd, input logic [15:0] px, input logic rdy);
        int   ones;
        bit   full;
        row_t r;
        ones = $countones(rd);
        full = (m_q.size() == RF);
        if (m_q.size() > 0 && rdy) begin
            if (m_col == H - 1) begin
                m_col = 0;
                void'(m_q.pop_front());
            end else begin
                m_col++;
            end
        end
        if (ones > 1) m_perr = 1;
        if (m_commit) begin
            m_commit = 0;
            if (full) m_ovf = 1;
            else begin
                r.row = m_idx;
                r.px  = m_sh;
                m_q.push_back(r);
            end
        end else if (m_cap) begin
            if (ones > 1) m_cap = 0;
            else if (rd[m_idx]) begin
                for (int j = 0; j < H; j++) m_sh[j] = px[j*DW +: DW];
            end else begin
                m_cap = 0;
                m_commit = 1;
            end
        end else if (ones == 1) begin
            for (int j = 0; j < H; j++) m_sh[j] = px[j*DW +: DW];
            m_idx = rd[1] ? 1 : 0;
            m_cap = 1;
        end
    endfunction

    function automatic logic [31:0] dut_vec();
        return {16'h0, out_valid, (out_valid ? out_data : 8'h00), out_col,
                (out_valid ? out_row : 1'b0), out_sof, out_eol, out_eof,
                overflow, proto_err};
    endfunction

    function automatic logic [31:0] model_vec();
        logic       v;
        logic [7:0] d;
        logic       r, c, sof, eol, eof;
        v = (m_q.size() > 0);
        d = v ? m_q[0].px[m_col] : 8'h00;
        r = v ? 1'(m_q[0].row) : 1'b0;
        c = 1'(m_col);
        sof = v && m_q[0].row == 0 && m_col == 0;
        eol = v && m_col == H - 1;
        eof = eol && m_q[0].row == V - 1;
        return {16'h0, v, d, c, r, sof, eol, eof, 1'(m_ovf), 1'(m_perr)};
    endfunction

    // One clock: drive inputs, step model at the edge, compare 1 ns later.
    task automatic cycle(input logic [1:0] rd, input logic [15:0] px, input logic rdy);
        read = rd; pix_data = px; out_ready = rdy;
        @(posedge clk);
        m_step(rd, px, rdy);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        reset = 1'b1; read = '0; out_ready = 1'b0;
        #1;
        check("async_reset", dut_vec(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        check("after_reset", dut_vec(), model_vec());
    endtask

    task automatic put_row(input logic [1:0] rd, input logic [15:0] px, input logic rdy);
        cycle(rd, px, rdy);
        cycle(2'b00, 16'hFFFF, rdy);
        cycle(2'b00, 16'hFFFF, rdy);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  rd;
        logic [15:0] px;
        logic        v;
        logic [7:0]  d;
        logic        c, r, sof, eol, eof;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [1:0] rd, input logic [15:0] px, input logic v,
                                input logic [7:0] d, input logic c, input logic r,
                                input logic sof, input logic eol, input logic eof);
        vec_t t;
        t.rd = rd; t.px = px; t.v = v; t.d = d; t.c = c; t.r = r;
        t.sof = sof; t.eol = eol; t.eof = eof;
        return t;
    endfunction

    logic [1:0] rnd_read;

    initial begin
        // lane 0 sits in the low byte of the bus
        tbl[0]  = mk(2'b01, 16'h2211, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(2'b01, 16'h2211, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[2]  = mk(2'b01, 16'h4433, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[3]  = mk(2'b00, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[4]  = mk(2'b00, 16'hFFFF, 1, 8'h33, 0, 0, 1, 0, 0);
        tbl[5]  = mk(2'b00, 16'hFFFF, 1, 8'h44, 1, 0, 0, 1, 0);
        tbl[6]  = mk(2'b00, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[7]  = mk(2'b01, 16'h0B0A, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[8]  = mk(2'b00, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[9]  = mk(2'b00, 16'hFFFF, 1, 8'h0A, 0, 0, 1, 0, 0);
        tbl[10] = mk(2'b10, 16'h0D0C, 1, 8'h0B, 1, 0, 0, 1, 0);
        tbl[11] = mk(2'b00, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[12] = mk(2'b00, 16'hFFFF, 1, 8'h0C, 0, 1, 0, 0, 0);
        tbl[13] = mk(2'b00, 16'hFFFF, 1, 8'h0D, 1, 1, 0, 1, 1);
        tbl[14] = mk(2'b00, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0);

        m_reset();
        do_reset();

        // single row then full frame, ready held high
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rd, tbl[i].px, 1'b1);
            check("table", dut_vec(),
                  {16'h0, tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r,
                   tbl[i].sof, tbl[i].eol, tbl[i].eof, 1'b0, 1'b0});
        end

        // three rows into a two-row FIFO while stalled
        do_reset();
        put_row(2'b01, 16'hA1A0, 1'b0);
        put_row(2'b10, 16'hB1B0, 1'b0);
        put_row(2'b01, 16'hC1C0, 1'b0);
        check("overflow", {31'h0, overflow}, 32'h1);
        check("ovf_head", {24'h0, out_data}, 32'hA0);
        for (int i = 0; i < 6; i++) cycle(2'b00, 16'hFFFF, 1'b1);
        check("ovf_drained", {31'h0, out_valid}, 32'h0);

        // multi-hot in the middle of a capture
        do_reset();
        cycle(2'b01, 16'h5150, 1'b1);
        cycle(2'b11, 16'h5352, 1'b1);
        check("proto_err", {31'h0, proto_err}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(2'b00, 16'hFFFF, 1'b1);
        check("no_push", {31'h0, out_valid}, 32'h0);

        // ready toggling every clock with two rows buffered
        do_reset();
        put_row(2'b01, 16'h6160, 1'b0);
        put_row(2'b10, 16'h7170, 1'b0);
        for (int i = 0; i < 10; i++) cycle(2'b00, 16'hFFFF, 1'(i % 2 == 0));
        check("toggle_drained", {31'h0, out_valid}, 32'h0);

        // reset asserted mid-capture with one row buffered
        do_reset();
        put_row(2'b01, 16'h8180, 1'b0);
        cycle(2'b10, 16'h9190, 1'b0);
        cycle(2'b10, 16'h9190, 1'b0);
        reset = 1'b1;
        #1;
        check("midrow_reset", dut_vec(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        check("midrow_clean", dut_vec(), model_vec());
        put_row(2'b01, 16'hE1E0, 1'b1);
        check("clean_sof", {23'h0, out_valid, out_data, out_sof}, {23'h0, 1'b1, 8'hE0, 1'b1});
        cycle(2'b00, 16'hFFFF, 1'b1);
        cycle(2'b00, 16'hFFFF, 1'b1);

        // random traffic against the model
        rnd_read = '0;
        for (int i = 0; i < 3000; i++) begin
            int p;
            if (i % 500 == 0) do_reset();
            p = $urandom_range(0, 99);
            if (p < 60)      rnd_read = rnd_read;
            else if (p < 75) rnd_read = 2'b00;
            else if (p < 86) rnd_read = 2'b01;
            else if (p < 97) rnd_read = 2'b10;
            else             rnd_read = 2'b11;
            cycle(rnd_read, 16'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
